// File: rtl/time_keeper_rtc.sv
// time_keeper_rtc: day/hour/minute/second time keeper with button time setting.
// Each button has a three-stage auto-repeat: initial delay, hold rate, then an
// accelerated rate. The hour is also presented as a 12-hour value with a PM flag.
// Optional feature macro TK_DECR_EN adds i_decr_n. While it is held low, each
// set-mode step decrements instead of incrementing.
module time_keeper_rtc #(
    parameter int unsigned g_clk_freq   = 20000,
    parameter int unsigned g_btn_init   = 20000,
    parameter int unsigned g_btn_hold   = 5000,
    parameter int unsigned g_btn_fast   = 1000,
    parameter int unsigned g_fast_after = 8
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_set_time_n,
    input  logic       i_incr_day_n,
    input  logic       i_incr_hr_n,
    input  logic       i_incr_min_n,
`ifdef TK_DECR_EN
    input  logic       i_decr_n,
`endif
    output logic [6:0] o_day,
    output logic [4:0] o_hour,
    output logic [5:0] o_minute,
    output logic [5:0] o_second,
    output logic [3:0] o_hour_12,
    output logic       o_pm,
    output logic       o_sec_tick
);

    localparam int unsigned PW = (g_clk_freq > 1) ? $clog2(g_clk_freq) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(g_clk_freq - 1);

    localparam int unsigned MAX_A   = (g_btn_init > g_btn_hold) ? g_btn_init : g_btn_hold;
    localparam int unsigned MAX_CNT = (MAX_A > g_btn_fast) ? MAX_A : g_btn_fast;
    localparam int unsigned CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam logic [CW-1:0] INIT_T = CW'(g_btn_init - 1);
    localparam logic [CW-1:0] HOLD_T = CW'(g_btn_hold - 1);
    localparam logic [CW-1:0] FAST_T = CW'(g_btn_fast - 1);

    localparam int unsigned RW = (g_fast_after > 1) ? $clog2(g_fast_after) : 1;
    localparam logic [RW-1:0] REP_T = RW'(g_fast_after - 1);

    // Button index: 0 = minute, 1 = hour, 2 = day
    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        HOLD,
        FAST
    } rep_state_t;

    logic [2:0]    btn_s1, btn_s2;
    logic          set_s1, set_s2;
    logic          set_mode;
    logic          decr;

    rep_state_t    state_q [3];
    rep_state_t    state_d [3];
    logic [CW-1:0] cnt_q   [3];
    logic [CW-1:0] cnt_d   [3];
    logic [RW-1:0] rep_q   [3];
    logic [RW-1:0] rep_d   [3];
    logic [2:0]    step;

    logic [PW-1:0] presc;

    assign set_mode = ~set_s2;

    // Two-flop synchronisers for the mode switch and buttons (released = 1)
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            btn_s1 <= '1;
            btn_s2 <= '1;
            set_s1 <= 1'b1;
            set_s2 <= 1'b1;
        end else begin
            btn_s1 <= {i_incr_day_n, i_incr_hr_n, i_incr_min_n};
            btn_s2 <= btn_s1;
            set_s1 <= i_set_time_n;
            set_s2 <= set_s1;
        end
    end

`ifdef TK_DECR_EN
    logic decr_s1, decr_s2;

    // Two-flop synchroniser for the decrement modifier
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            decr_s1 <= 1'b1;
            decr_s2 <= 1'b1;
        end else begin
            decr_s1 <= i_decr_n;
            decr_s2 <= decr_s1;
        end
    end

    assign decr = ~decr_s2;
`else
    assign decr = 1'b0;
`endif

    // Repeat FSM state registers, one set per button
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int unsigned i = 0; i < 3; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
                rep_q[i]   <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                rep_q[i]   <= rep_d[i];
            end
        end
    end

    // Repeat FSM next state and step pulses; the IDLE state doubles as the
    // edge detector, so a held button entering IDLE counts as a fresh press
    always_comb begin
        step = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            rep_d[i]   = rep_q[i];
            if (!set_mode || btn_s2[i]) begin
                state_d[i] = IDLE;
                cnt_d[i]   = '0;
                rep_d[i]   = '0;
            end else begin
                unique case (state_q[i])
                    IDLE: begin
                        step[i]    = 1'b1;
                        state_d[i] = FIRST;
                        cnt_d[i]   = '0;
                    end
                    FIRST: begin
                        if (cnt_q[i] == INIT_T) begin
                            step[i]    = 1'b1;
                            state_d[i] = HOLD;
                            cnt_d[i]   = '0;
                            rep_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CW'(1);
                        end
                    end
                    HOLD: begin
                        if (cnt_q[i] == HOLD_T) begin
                            step[i]  = 1'b1;
                            cnt_d[i] = '0;
                            if (rep_q[i] == REP_T) begin
                                state_d[i] = FAST;
                                rep_d[i]   = '0;
                            end else begin
                                rep_d[i] = rep_q[i] + RW'(1);
                            end
                        end else begin
                            cnt_d[i] = cnt_q[i] + CW'(1);
                        end
                    end
                    FAST: begin
                        if (cnt_q[i] == FAST_T) begin
                            step[i]  = 1'b1;
                            cnt_d[i] = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CW'(1);
                        end
                    end
                    default: begin
                        state_d[i] = IDLE;
                    end
                endcase
            end
        end
    end

    // Time registers: set-mode steps without carry, run-mode counting with carry
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            presc      <= '0;
            o_sec_tick <= 1'b0;
            o_second   <= '0;
            o_minute   <= '0;
            o_hour     <= '0;
            o_day      <= 7'b0000001;
        end else begin
            o_sec_tick <= 1'b0;
            if (set_mode) begin
                presc    <= '0;
                o_second <= '0;
                if (step[0]) begin
                    if (decr) o_minute <= (o_minute == 6'd0)  ? 6'd59 : o_minute - 6'd1;
                    else      o_minute <= (o_minute == 6'd59) ? 6'd0  : o_minute + 6'd1;
                end
                if (step[1]) begin
                    if (decr) o_hour <= (o_hour == 5'd0)  ? 5'd23 : o_hour - 5'd1;
                    else      o_hour <= (o_hour == 5'd23) ? 5'd0  : o_hour + 5'd1;
                end
                if (step[2]) begin
                    if (decr) o_day <= {o_day[0], o_day[6:1]};
                    else      o_day <= {o_day[5:0], o_day[6]};
                end
            end else if (presc == PRESC_MAX) begin
                presc      <= '0;
                o_sec_tick <= 1'b1;
                if (o_second == 6'd59) begin
                    o_second <= '0;
                    if (o_minute == 6'd59) begin
                        o_minute <= '0;
                        if (o_hour == 5'd23) begin
                            o_hour <= '0;
                            o_day  <= {o_day[5:0], o_day[6]};
                        end else begin
                            o_hour <= o_hour + 5'd1;
                        end
                    end else begin
                        o_minute <= o_minute + 6'd1;
                    end
                end else begin
                    o_second <= o_second + 6'd1;
                end
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    // 12-hour display view
    always_comb begin
        o_hour_12 = o_hour[3:0];
        if (o_hour == 5'd0) begin
            o_hour_12 = 4'd12;
        end else if (o_hour > 5'd12) begin
            o_hour_12 = 4'(o_hour - 5'd12);
        end
        o_pm = (o_hour >= 5'd12);
    end

endmodule

// File: tb/tb_time_keeper_rtc.sv
// Directed testbench for time_keeper_rtc with small timing parameters.
// Also covers the TK_DECR_EN build when that macro is defined.
module tb_time_keeper_rtc;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_set_time_n = 1'b1;
    logic       i_incr_day_n = 1'b1;
    logic       i_incr_hr_n = 1'b1;
    logic       i_incr_min_n = 1'b1;
`ifdef TK_DECR_EN
    logic       i_decr_n = 1'b1;
`endif
    logic [6:0] o_day;
    logic [4:0] o_hour;
    logic [5:0] o_minute;
    logic [5:0] o_second;
    logic [3:0] o_hour_12;
    logic       o_pm;
    logic       o_sec_tick;

    int n_checks = 0;
    int n_fail = 0;
    int ticks;
    int exp_min;

    time_keeper_rtc #(
        .g_clk_freq(5),
        .g_btn_init(5),
        .g_btn_hold(3),
        .g_btn_fast(1),
        .g_fast_after(4)
    ) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .i_set_time_n(i_set_time_n),
        .i_incr_day_n(i_incr_day_n),
        .i_incr_hr_n(i_incr_hr_n),
        .i_incr_min_n(i_incr_min_n),
`ifdef TK_DECR_EN
        .i_decr_n(i_decr_n),
`endif
        .o_day(o_day),
        .o_hour(o_hour),
        .o_minute(o_minute),
        .o_second(o_second),
        .o_hour_12(o_hour_12),
        .o_pm(o_pm),
        .o_sec_tick(o_sec_tick)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges; sample point is 1 time unit after the edge
    task automatic tick_clk(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    // One short press per iteration; mask bit2 = day, bit1 = hour, bit0 = minute
    task automatic tap(input logic [2:0] mask, input int n);
        for (int t = 0; t < n; t++) begin
            i_incr_day_n = ~mask[2];
            i_incr_hr_n  = ~mask[1];
            i_incr_min_n = ~mask[0];
            tick_clk(2);
            i_incr_day_n = 1'b1;
            i_incr_hr_n  = 1'b1;
            i_incr_min_n = 1'b1;
            tick_clk(4);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_day"}, o_day, 1);
        check({tag, "_hour"}, o_hour, 0);
        check({tag, "_min"}, o_minute, 0);
        check({tag, "_sec"}, o_second, 0);
        check({tag, "_tick"}, o_sec_tick, 0);
    endtask

    initial begin
        // Reset state
        #12;
        check_reset_vals("rst");
        check("rst_h12", o_hour_12, 12);
        check("rst_pm", o_pm, 0);
        i_reset = 1'b0;

        // Run 300 cycles: 60 ticks, one minute
        ticks = 0;
        for (int k = 1; k <= 300; k++) begin
            tick_clk(1);
            ticks += int'(o_sec_tick);
            if (k == 5) check("first_tick", o_sec_tick, 1);
        end
        check("run_min", o_minute, 1);
        check("run_sec", o_second, 0);
        check("run_ticks", ticks, 60);

        // Set mode: second clears and holds, no ticks
        i_set_time_n = 1'b0;
        tick_clk(3);
        check("set_sec_clr", o_second, 0);
        ticks = 0;
        for (int k = 0; k < 8; k++) begin
            tick_clk(1);
            ticks += int'(o_sec_tick);
        end
        check("set_no_tick", ticks, 0);
        check("set_sec_hold", o_second, 0);

        // Set Saturday 23:59 using simultaneous and single presses
        tap(3'b111, 6);
        tap(3'b011, 17);
        tap(3'b001, 35);
        check("sat_day", o_day, 64);
        check("sat_hour", o_hour, 23);
        check("sat_min", o_minute, 59);
        check("sat_h12", o_hour_12, 11);
        check("sat_pm", o_pm, 1);

        // Leave set mode: first tick 5 cycles after synced rising edge
        i_set_time_n = 1'b1;
        ticks = 0;
        for (int k = 1; k <= 6; k++) begin
            tick_clk(1);
            ticks += int'(o_sec_tick);
        end
        check("exit_no_early_tick", ticks, 0);
        tick_clk(1);
        check("exit_first_tick", o_sec_tick, 1);
        check("exit_sec1", o_second, 1);
        tick_clk(294);
        check("pre_roll_sec", o_second, 59);
        check("pre_roll_min", o_minute, 59);
        check("pre_roll_hour", o_hour, 23);
        check("pre_roll_day", o_day, 64);
        tick_clk(1);
        check("roll_tick", o_sec_tick, 1);
        check("roll_sec", o_second, 0);
        check("roll_min", o_minute, 0);
        check("roll_hour", o_hour, 0);
        check("roll_day", o_day, 1);

        // Held minute button: auto-repeat schedule
        i_set_time_n = 1'b0;
        tick_clk(4);
        exp_min = 0;
        check("hold_start", o_minute, exp_min);
        i_incr_min_n = 1'b0;
        for (int k = 1; k <= 35; k++) begin
            tick_clk(1);
            if (k == 3 || k == 8 || k == 11 || k == 14 || k == 17 || k == 20 ||
                (k >= 21 && k <= 30)) exp_min++;
            check($sformatf("hold_min@%0d", k), o_minute, exp_min);
            if (k == 28) i_incr_min_n = 1'b1;
        end
        check("hold_final", o_minute, 16);
        check("hold_hour", o_hour, 0);

        // Set-mode wraps without carry
        tap(3'b011, 5);
        tap(3'b001, 38);
        check("wrap_pre_min", o_minute, 59);
        check("wrap_pre_hour", o_hour, 5);
        tap(3'b001, 1);
        check("wrap_min", o_minute, 0);
        check("wrap_min_hour", o_hour, 5);
        tap(3'b100, 6);
        check("day_sat", o_day, 64);
        tap(3'b100, 1);
        check("day_wrap", o_day, 1);

        // Hour steps and 12-hour view
        tap(3'b010, 19);
        check("h0_hour", o_hour, 0);
        check("h0_day", o_day, 1);
        check("h0_h12", o_hour_12, 12);
        check("h0_pm", o_pm, 0);
        tap(3'b010, 11);
        check("h11_h12", o_hour_12, 11);
        check("h11_pm", o_pm, 0);
        tap(3'b010, 1);
        check("h12_h12", o_hour_12, 12);
        check("h12_pm", o_pm, 1);
        tap(3'b010, 1);
        check("h13_h12", o_hour_12, 1);
        check("h13_pm", o_pm, 1);
        tap(3'b010, 10);
        check("h23_hour", o_hour, 23);
        check("h23_h12", o_hour_12, 11);
        check("h23_pm", o_pm, 1);

        // Reset mid-hold, then held button counts as a new press
        i_incr_min_n = 1'b0;
        tick_clk(10);
        #2 i_reset = 1'b1;
        #1;
        check_reset_vals("rst_hold");
        #1 i_reset = 1'b0;
        tick_clk(2);
        check("post_rst_min2", o_minute, 0);
        tick_clk(1);
        check("post_rst_min3", o_minute, 1);
        i_incr_min_n = 1'b1;
        tick_clk(4);

        // Reset mid-run
        i_set_time_n = 1'b1;
        tick_clk(12);
        check("run_sec2", o_second, 2);
        #2 i_reset = 1'b1;
        #1;
        check_reset_vals("rst_run");
        #1 i_reset = 1'b0;
        tick_clk(2);

`ifdef TK_DECR_EN
        // Decrement wraps
        i_set_time_n = 1'b0;
        tick_clk(4);
        i_decr_n = 1'b0;
        tick_clk(3);
        tap(3'b001, 1);
        check("dec_min", o_minute, 59);
        tap(3'b100, 1);
        check("dec_day", o_day, 64);
        tap(3'b010, 1);
        check("dec_hour", o_hour, 23);
        i_decr_n = 1'b1;
        tick_clk(3);
        tap(3'b001, 1);
        check("dec_off_min", o_minute, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
